alu_exec_seq: RTL

- Execution-side consumer of the 3-bit aluControl code produced by the ALU decode stage.
- Accepts operands plus aluControl through a valid/ready handshake and executes the operation.
- Returns a registered result and zero flag through a second valid/ready handshake.
- Add, sub, logic and slt complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter, for area-constrained multi-cycle cores.

---
 rtl/alu_exec_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_seq.sv
// -----------------------------------------------------------------------------
// alu_exec_seq
//   Execution-side consumer of the 3-bit aluControl code from ALU decode.
//   An operation (a, b, aluControl) is accepted through an in_valid/in_ready
//   handshake. The result and zero flag are returned, registered, through an
//   out_valid/out_ready handshake.
//   Add, sub, xor, or, and and slt complete in one cycle. Shifts use an
//   iterative shifter that moves one bit per cycle, which keeps the shifter
//   small in multi-cycle cores.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    operands and aluControl are valid
//   in_ready    block can accept an operation (state == IDLE)
//   a, b        operands; the shift amount is b[SHW-1:0]
//   aluControl  000 add, 001 sub, 010 xor, 011 or, 100 and,
//               101 sll, 110 srl, 111 slt (signed)
//   out_valid   result and zero are valid (state == DONE)
//   out_ready   downstream accepts the result
//   result      operation result
//   zero        high when result == 0
//
// States
//   state | meaning
//   IDLE  | waiting for an operation; in_ready is high
//   SHIFT | iterative shift in progress; cnt holds the remaining bit steps
//   DONE  | result/zero are valid and held until out_ready is high
// -----------------------------------------------------------------------------
module alu_exec_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             dir_right;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] work_next;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = b[SHW-1:0];
  assign is_shift  = (aluControl == OP_SLL) || (aluControl == OP_SRL);

  // Single-cycle datapath. The shift codes never select this path, so they
  // fall through to zero.
  always_comb begin
    alu_res = '0;
    case (aluControl)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter. The shift is always logical, so
  // both directions fill with zeros.
  always_comb begin
    work_next = '0;
    if (dir_right) work_next = {1'b0, work[WIDTH-1:1]};
    else           work_next = {work[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_shift) begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              state  <= DONE;
            end else if (shamt == '0) begin
              result <= a;
              zero   <= (a == '0);
              state  <= DONE;
            end else begin
              work      <= a;
              cnt       <= shamt;
              dir_right <= (aluControl == OP_SRL);
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - SHW'(1);
          // The last step writes the shifted value directly into result, so
          // zero never reflects an intermediate value.
          if (cnt == SHW'(1)) begin
            result <= work_next;
            zero   <= (work_next == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
